// File: rtl/gb_interrupt_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, IME sequencing with delayed EI,
// fixed-priority selection and the CPU dispatch handshake.
module gb_interrupt_ctrl #(
  parameter int          NUM_IRQ    = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter int          VEC_STRIDE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [15:0]        addr_i,
  input  logic [7:0]         wdata_i,
  input  logic               wr_i,
  output logic [7:0]         rdata_o,
  output logic               sel_o,
  input  logic               instr_boundary_i,
  input  logic               ei_i,
  input  logic               di_i,
  input  logic               reti_i,
  input  logic               int_ack_i,
  output logic               int_req_o,
  output logic [15:0]        int_vector_o,
  output logic               vector_valid_o,
  output logic               ime_o,
  output logic               wake_o
);

  localparam int          IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic [1:0] {IME_OFF, IME_ARMED, IME_ON} ime_state_t;
  typedef enum logic       {DISP_IDLE, DISP_REQ} disp_state_t;

  logic [NUM_IRQ-1:0] if_q, if_next;
  logic [7:0]         ie_q;
  ime_state_t         ime_q, ime_next;
  disp_state_t        disp_q, disp_next;
  logic [15:0]        vec_q;
  logic               valid_q;

  logic               sel_if, sel_ie;
  logic [NUM_IRQ-1:0] pending, sel_onehot;
  logic [IDX_W-1:0]   sel_idx;
  logic               have_pending, dispatch_start, ack_fire;
  logic [15:0]        sel_vec;

  assign sel_if = (addr_i == ADDR_IF);
  assign sel_ie = (addr_i == ADDR_IE);
  assign sel_o  = sel_if | sel_ie;

  // Unimplemented IF bits read back as ones.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    rdata_o = 8'h00;
    if (sel_if) begin
      rdata_o                = 8'hFF;
      rdata_o[NUM_IRQ-1:0]   = if_q;
    end else if (sel_ie) begin
      rdata_o = ie_q;
    end
  end

  assign pending      = ie_q[NUM_IRQ-1:0] & if_q;
  assign have_pending = |pending;
  assign wake_o       = have_pending;

  // Scan from the top so the lowest set bit (highest priority) wins.
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx       = IDX_W'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign sel_vec = VEC_BASE + 16'(VEC_STRIDE) * 16'(sel_idx);

  assign ack_fire       = (disp_q == DISP_REQ) && int_ack_i;
  assign dispatch_start = (disp_q == DISP_IDLE) && instr_boundary_i &&
                          (ime_q == IME_ON) && have_pending;

  // Later assignments win: peripheral request > ack clear > CPU write.
  always_comb begin
    if_next = if_q;
    if (wr_i && sel_if) if_next = wdata_i[NUM_IRQ-1:0];
    if (ack_fire && have_pending) if_next = if_next & ~sel_onehot;
    if_next = if_next | irq_i;
  end

  always_comb begin
    ime_next = ime_q;
    case (ime_q)
      IME_OFF:   if (ei_i) ime_next = IME_ARMED;
      IME_ARMED: if (instr_boundary_i) ime_next = IME_ON;
      default:   ime_next = ime_q;
    endcase
    if (reti_i)         ime_next = IME_ON;
    if (dispatch_start) ime_next = IME_OFF;
    if (di_i)           ime_next = IME_OFF;
  end

  always_comb begin
    disp_next = disp_q;
    case (disp_q)
      DISP_IDLE: if (dispatch_start) disp_next = DISP_REQ;
      DISP_REQ:  if (int_ack_i) disp_next = DISP_IDLE;
      default:   disp_next = DISP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_q    <= '0;
      ie_q    <= 8'h00;
      ime_q   <= IME_OFF;
      disp_q  <= DISP_IDLE;
      vec_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if_q    <= if_next;
      ime_q   <= ime_next;
      disp_q  <= disp_next;
      valid_q <= ack_fire;
      if (wr_i && sel_ie) ie_q <= wdata_i;
      // A vanished pending set at ack yields the null vector.
      if (ack_fire) vec_q <= have_pending ? sel_vec : 16'h0000;
    end
  end

  assign int_req_o      = (disp_q == DISP_REQ);
  assign int_vector_o   = vec_q;
  assign vector_valid_o = valid_q;
  assign ime_o          = (ime_q == IME_ON);

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// Scoreboard bench for gb_interrupt_ctrl: directed scenarios then randomized traffic
// against a behavioural model; vectors are checked by a separate monitor.
module tb_gb_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  irq_i;
  logic [15:0] addr_i;
  logic [7:0]  wdata_i;
  logic        wr_i, instr_boundary_i, ei_i, di_i, reti_i, int_ack_i;
  logic [7:0]  rdata_o;
  logic        sel_o, int_req_o, vector_valid_o, ime_o, wake_o;
  logic [15:0] int_vector_o;

  gb_interrupt_ctrl dut (
    .clk(clk), .reset(reset), .irq_i(irq_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .wr_i(wr_i), .rdata_o(rdata_o), .sel_o(sel_o), .instr_boundary_i(instr_boundary_i),
    .ei_i(ei_i), .di_i(di_i), .reti_i(reti_i), .int_ack_i(int_ack_i),
    .int_req_o(int_req_o), .int_vector_o(int_vector_o), .vector_valid_o(vector_valid_o),
    .ime_o(ime_o), .wake_o(wake_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  // Reference model: IME tracked as "enabled" plus "enable waiting for a boundary".
  logic [4:0]  m_if;
  logic [7:0]  m_ie;
  logic        m_on, m_wait, m_req, m_valid;
  logic [15:0] m_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] vec_of(input logic [4:0] p);
    for (int i = 0; i < 5; i++)
      if (p[i]) return 16'h0040 + 16'(8 * i);
    return 16'h0000;
  endfunction

  function automatic logic [7:0] exp_read(input logic [15:0] a);
    if (a == 16'hFF0F) return {3'b111, m_if};
    if (a == 16'hFFFF) return m_ie;
    return 8'h00;
  endfunction

  task automatic clear_pulses();
    irq_i = '0; wr_i = 0; instr_boundary_i = 0;
    ei_i = 0; di_i = 0; reti_i = 0; int_ack_i = 0;
  endtask

  task automatic model_reset();
    m_if = '0; m_ie = '0; m_on = 0; m_wait = 0; m_req = 0; m_valid = 0; m_vec = '0;
  endtask

  // Advance the model with the inputs now on the pins, clock once, compare.
  task automatic step();
    logic [4:0] pend, nif;
    logic       ack, disp, on_n, w_n;
    pend = m_ie[4:0] & m_if;
    ack  = m_req && int_ack_i;
    disp = !m_req && instr_boundary_i && m_on && (pend != 0);
    nif  = m_if;
    if (wr_i && addr_i == 16'hFF0F) nif = wdata_i[4:0];
    if (ack) nif = nif & ~(pend & (~pend + 5'd1));
    nif = nif | irq_i;
    if (wr_i && addr_i == 16'hFFFF) m_ie = wdata_i;
    on_n = m_on; w_n = m_wait;
    if (ei_i && !m_on && !m_wait) w_n = 1;
    if (m_wait && instr_boundary_i) begin on_n = 1; w_n = 0; end
    if (reti_i) begin on_n = 1; w_n = 0; end
    if (disp)   begin on_n = 0; w_n = 0; end
    if (di_i)   begin on_n = 0; w_n = 0; end
    if (ack) begin
      m_vec = vec_of(pend);
      exp_q.push_back(m_vec);
      m_req = 0;
    end
    if (disp) m_req = 1;
    m_valid = ack; m_if = nif; m_on = on_n; m_wait = w_n;
    @(posedge clk); #1;
    check("int_req", int_req_o, m_req);
    check("ime", ime_o, m_on);
    check("wake", wake_o, |(m_ie[4:0] & m_if));
    check("valid", vector_valid_o, m_valid);
    check("vector_hold", int_vector_o, m_vec);
    check("rdata", rdata_o, exp_read(addr_i));
    check("sel", sel_o, (addr_i == 16'hFF0F) || (addr_i == 16'hFFFF));
    clear_pulses();
  endtask

  task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    addr_i = a;
    #1;
    check(name, rdata_o, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr_i = a; wdata_i = d; wr_i = 1;
    step();
  endtask

  task automatic do_reset();
    reset = 0;
    clear_pulses();
    #1;
    model_reset();
    check("rst_req", int_req_o, 0);
    check("rst_vec", int_vector_o, 16'h0000);
    check("rst_valid", vector_valid_o, 0);
    check("rst_ime", ime_o, 0);
    check("rst_wake", wake_o, 0);
    read_check("rst_if", 16'hFF0F, 8'hE0);
    read_check("rst_ie", 16'hFFFF, 8'h00);
    @(negedge clk);
    reset = 1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && vector_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL vector_unexpected: got %h with nothing expected at %0t", int_vector_o, $time);
      end else begin
        check("vector", int_vector_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    addr_i = 16'h0000; wdata_i = 8'h00;
    do_reset();

    // Priority selection and dispatch: bits 2 and 4 pending, bit 2 wins.
    wr(16'hFFFF, 8'h1F);
    reti_i = 1; step();
    irq_i = 5'b10100; step();
    instr_boundary_i = 1; step();
    check("tp2_req", int_req_o, 1);
    int_ack_i = 1; step();
    check("tp2_vec", int_vector_o, 16'h0050);
    check("tp2_valid", vector_valid_o, 1);
    check("tp2_ime", ime_o, 0);
    read_check("tp2_if", 16'hFF0F, 8'hF0);
    wr(16'hFF0F, 8'h00);

    // IE cleared between request and ack yields the null vector.
    wr(16'hFFFF, 8'h04);
    irq_i = 5'b00100; step();
    reti_i = 1; step();
    instr_boundary_i = 1; step();
    check("tp4_req", int_req_o, 1);
    wr(16'hFFFF, 8'h00);
    int_ack_i = 1; step();
    check("tp4_vec", int_vector_o, 16'h0000);
    check("tp4_valid", vector_valid_o, 1);
    read_check("tp4_if", 16'hFF0F, 8'hE4);
    wr(16'hFF0F, 8'h00);

    // EI delay: EI on its own boundary A, IME on after B, dispatch at the next one.
    wr(16'hFFFF, 8'h01);
    irq_i = 5'b00001; step();
    ei_i = 1; instr_boundary_i = 1; step();
    check("tp3_ime_a", ime_o, 0);
    instr_boundary_i = 1; step();
    check("tp3_ime_b", ime_o, 1);
    check("tp3_req_b", int_req_o, 0);
    instr_boundary_i = 1; step();
    check("tp3_req_c", int_req_o, 1);
    int_ack_i = 1; step();
    check("tp3_vec", int_vector_o, 16'h0040);

    // Request beats a coincident write of zero; DI beats EI.
    addr_i = 16'hFF0F; wdata_i = 8'h00; wr_i = 1; irq_i = 5'b00010; step();
    read_check("tp5_if", 16'hFF0F, 8'hE2);
    di_i = 1; ei_i = 1; step();
    check("tp5_ime0", ime_o, 0);
    instr_boundary_i = 1; step();
    instr_boundary_i = 1; step();
    check("tp5_ime1", ime_o, 0);
    wr(16'hFF0F, 8'h00);

    // Wake without IME, then reset in the middle of a request.
    di_i = 1; step();
    wr(16'hFFFF, 8'h10);
    irq_i = 5'b10000; step();
    check("tp6_wake", wake_o, 1);
    for (int i = 0; i < 3; i++) begin
      instr_boundary_i = 1; step();
      check("tp6_noreq", int_req_o, 0);
    end
    reti_i = 1; step();
    instr_boundary_i = 1; step();
    check("tp6_req", int_req_o, 1);
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      case ($urandom % 4)
        0: addr_i = 16'hFF0F;
        1: addr_i = 16'hFFFF;
        2: addr_i = 16'hFF0F;
        default: addr_i = 16'($urandom);
      endcase
      if ($urandom % 8 == 0) begin wr_i = 1; wdata_i = 8'($urandom); end
      if ($urandom % 6 == 0) irq_i = 5'($urandom);
      instr_boundary_i = ($urandom % 4 == 0);
      ei_i = ($urandom % 16 == 0);
      if (!instr_boundary_i) begin
        di_i   = ($urandom % 24 == 0);
        reti_i = !di_i && ($urandom % 20 == 0);
      end
      int_ack_i = m_req ? ($urandom % 3 == 0) : ($urandom % 20 == 0);
      step();
    end

    for (int i = 0; i < 3; i++) step();
    check("vector_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gb_interrupt_ctrl.md
Name: gb_interrupt_ctrl

Overview:
Interrupt controller sitting directly upstream of gb_cpu. It owns the IF (0xFF0F) and IE (0xFFFF) registers, the IME flag and its delayed-enable sequencing, and fixed-priority interrupt selection. It raises a dispatch request at instruction boundaries, supplies the handler vector when the CPU acknowledges, and provides the HALT wake indication.

Parameters:
NUM_IRQ, 5, number of interrupt sources (bit 0 = VBlank, highest priority … bit 4 = Joypad)
VEC_BASE, 16'h0040, vector of bit 0
VEC_STRIDE, 8, byte spacing between consecutive vectors

Ports:
clk  in  1  machine (M) clock
reset  in  1  asynchronous, active-low reset
irq_i  in  NUM_IRQ  one-cycle request pulses from peripherals
addr_i  in  16  CPU address bus
wdata_i  in  8  CPU write data
wr_i  in  1  CPU write strobe, one cycle per write
rdata_o  out  8  read data for IF/IE; 8'h00 when not selected
sel_o  out  1  addr_i hits 0xFF0F or 0xFFFF
instr_boundary_i  in  1  pulse in the last M-cycle of every instruction
ei_i  in  1  EI executed (pulse)
di_i  in  1  DI executed (pulse)
reti_i  in  1  RETI executed (pulse)
int_ack_i  in  1  CPU dispatch m-cycle where the vector is sampled (pulse)
int_req_o  out  1  dispatch request to CPU
int_vector_o  out  16  handler address, valid with vector_valid_o
vector_valid_o  out  1  one-cycle strobe, the cycle after int_ack_i
ime_o  out  1  current IME
wake_o  out  1  |(IE & IF), independent of IME (HALT exit)

Behaviour:
- Reset (async, reset=0): IF=0, IE=0, IME state OFF, dispatch FSM IDLE. int_req_o=0, int_vector_o=16'h0000, vector_valid_o=0, ime_o=0, wake_o=0. Reset mid-dispatch abandons the dispatch with no ack pending.
- Registers: IF is 5 bits; a read returns {3'b111, IF}. IE is a full 8 bits, read/write. rdata_o is combinational from addr_i. Writes take effect at the posedge when wr_i=1.
- Per-bit IF update priority in one cycle: irq_i set > ack clear > CPU write. A request pulse coincident with a write of 0 leaves the bit at 1.
- pending = IE[4:0] & IF. Selection is the lowest set bit. Vector = VEC_BASE + idx*VEC_STRIDE (0x40, 0x48, 0x50, 0x58, 0x60).
- IME FSM, states OFF / ARMED / ON:
  - ei_i: OFF→ARMED. ARMED→ON on the first instr_boundary_i strictly after the ei_i cycle, i.e. at the end of the instruction following EI. ei_i in ON has no effect.
  - di_i: any state→OFF the next cycle. di_i beats a coincident ei_i or boundary.
  - reti_i: →ON immediately, with no delay.
  - ime_o=1 only in ON.
- Dispatch FSM, states IDLE / REQ:
  - IDLE→REQ at a cycle with instr_boundary_i=1, IME=ON and pending≠0. In that same edge IME→OFF.
  - REQ holds int_req_o=1 until int_ack_i.
  - On int_ack_i, pending is re-evaluated at that cycle. If nonzero, the selected IF bit is cleared and int_vector_o is set to its vector. If zero (IE/IF changed during the CPU push), int_vector_o=16'h0000 and no IF bit is cleared. vector_valid_o pulses for one cycle, and the FSM returns to IDLE.
  - int_ack_i in IDLE is ignored. int_vector_o holds its value until the next ack.
  - ei_i/reti_i while in REQ update the IME state but do not start a second request.
- A boundary in ARMED does not dispatch; the IME becomes ON on that edge, so dispatch is earliest at the next boundary.
- wake_o is combinational from the current IE/IF.

Test Plan:
- Reset, then read 0xFF0F → 8'hE0; read 0xFFFF → 8'h00; int_req_o=0, ime_o=0.
- IE=0x1F, IME ON, irq_i=5'b10100, boundary → int_req_o=1; ack → int_vector_o=0x0050, vector_valid_o pulse, IF reads 0xF0, ime_o=0.
- ei_i, boundary A, boundary B, with IE=IF=0x01 pending throughout → ime_o=0 after A, 1 after B; int_req_o rises only at the boundary after B.
- In REQ with IF=0x04, write IE=0x00 before ack → vector 0x0000, IF unchanged at 0xE4.
- Same cycle: irq_i[1]=1 and write IF=0x00 → IF reads 0xE2; di_i coincident with ei_i → ime_o stays 0.
- IME OFF, IE=0x10, irq_i[4] pulse → wake_o=1 and int_req_o stays 0 across boundaries; reset low during REQ → all outputs return to reset values.
